// File: rtl/edge_event_detector.sv
// Per-channel synchroniser + debounce filter feeding a mode-selectable edge pulse
// with sticky pending/overflow flags; pulse lands SYNC_STAGES+DEBOUNCE_CYCLES edges after input settles.
module edge_event_detector #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   signal_in,
  input  logic [2*WIDTH-1:0] edge_mode,
  input  logic [WIDTH-1:0]   clear,
  output logic [WIDTH-1:0]   signal_clean,
  output logic [WIDTH-1:0]   edge_detect_pulse,
  output logic [WIDTH-1:0]   edge_pending,
  output logic [WIDTH-1:0]   edge_overflow
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] overflow_q, overflow_d;
  logic [WIDTH-1:0] sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = signal_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end

    clean_d = clean_q;
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Mode is only consulted here, at the moment the clean level flips.
          clean_d[i] = sync_out[i];
          pulse_d[i] = sync_out[i] ? edge_mode[2*i] : edge_mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    pending_d  = pulse_d | (pending_q & ~clear);
    overflow_d = ~clear & (overflow_q | (pulse_d & pending_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      clean_q    <= '0;
      pulse_q    <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      clean_q    <= clean_d;
      pulse_q    <= pulse_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign signal_clean      = clean_q;
  assign edge_detect_pulse = pulse_q;
  assign edge_pending      = pending_q;
  assign edge_overflow     = overflow_q;

endmodule
